ps2_rx_decod: RTL and testbench

Receives serial PS/2 keyboard frames (scan code set 2), validates them, and decodes key presses into the single-cycle command pulses `ctrl`, `enter` and `dato` plus a 4-bit hex value. It sits directly upstream of the capture control FSM, which consumes these pulses to sequence data entry and raise its save strobe. Key releases (break codes) and unrecognised keys produce no pulse.

---
 rtl/ps2_pkg.sv | 61 ++++++
 rtl/ps2_filtro.sv | 57 +++++
 rtl/ps2_rx_decod.sv | 162 ++++++++++++++++
 tb/tb_ps2_rx_decod.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 keyboard receiver.
//   * scan code set 2 constants (command keys, prefixes, hex digits)
//   * frame FSM state encoding (2 bits)
//   * sc_to_hex(): maps a scan code to a {valid, hex} pair
package ps2_pkg;

   localparam logic [7:0] SC_CTRL  = 8'h14;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;

   localparam logic [7:0] SC_D0 = 8'h45;
   localparam logic [7:0] SC_D1 = 8'h16;
   localparam logic [7:0] SC_D2 = 8'h1E;
   localparam logic [7:0] SC_D3 = 8'h26;
   localparam logic [7:0] SC_D4 = 8'h25;
   localparam logic [7:0] SC_D5 = 8'h2E;
   localparam logic [7:0] SC_D6 = 8'h36;
   localparam logic [7:0] SC_D7 = 8'h3D;
   localparam logic [7:0] SC_D8 = 8'h3E;
   localparam logic [7:0] SC_D9 = 8'h46;
   localparam logic [7:0] SC_DA = 8'h1C;
   localparam logic [7:0] SC_DB = 8'h32;
   localparam logic [7:0] SC_DC = 8'h21;
   localparam logic [7:0] SC_DD = 8'h23;
   localparam logic [7:0] SC_DE = 8'h24;
   localparam logic [7:0] SC_DF = 8'h2B;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_DATA = 2'd1,
      RX_PAR  = 2'd2,
      RX_STOP = 2'd3
   } rx_state_t;

   // Returns {valid, hex}; valid=0 for any code that is not a hex digit key.
   function automatic logic [4:0] sc_to_hex(input logic [7:0] sc);
      logic [4:0] r;
      case (sc)
         SC_D0:   r = {1'b1, 4'h0};
         SC_D1:   r = {1'b1, 4'h1};
         SC_D2:   r = {1'b1, 4'h2};
         SC_D3:   r = {1'b1, 4'h3};
         SC_D4:   r = {1'b1, 4'h4};
         SC_D5:   r = {1'b1, 4'h5};
         SC_D6:   r = {1'b1, 4'h6};
         SC_D7:   r = {1'b1, 4'h7};
         SC_D8:   r = {1'b1, 4'h8};
         SC_D9:   r = {1'b1, 4'h9};
         SC_DA:   r = {1'b1, 4'hA};
         SC_DB:   r = {1'b1, 4'hB};
         SC_DC:   r = {1'b1, 4'hC};
         SC_DD:   r = {1'b1, 4'hD};
         SC_DE:   r = {1'b1, 4'hE};
         SC_DF:   r = {1'b1, 4'hF};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_filtro.sv
// ps2_filtro -- PS/2 line conditioning.
//   Two-flop synchronisers on ps2c/ps2d, a glitch filter on ps2c that only
//   accepts a new level after FILTRO_LEN identical samples, and a registered
//   falling-edge pulse of the filtered clock.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   ps2c, ps2d raw PS/2 clock / data pins (asynchronous)
//   fe         one-cycle pulse on a filtered 1->0 transition of ps2c
//   ps2d_s     synchronised data line, to be sampled when fe=1
module ps2_filtro #(
   parameter int FILTRO_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2c,
   input  logic ps2d,
   output logic fe,
   output logic ps2d_s
);

   localparam logic [4:0] CNT_MAX = 5'(FILTRO_LEN - 1);

   logic       ps2c_p0, ps2c_p1;
   logic       ps2d_p0;
   logic       filt;
   logic [4:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps2c_p0 <= 1'b1;
         ps2c_p1 <= 1'b1;
         ps2d_p0 <= 1'b1;
         ps2d_s  <= 1'b1;
         filt    <= 1'b1;
         cnt     <= 5'd0;
         fe      <= 1'b0;
      end else begin
         // synchroniser stages
         ps2c_p0 <= ps2c;
         ps2c_p1 <= ps2c_p0;
         ps2d_p0 <= ps2d;
         ps2d_s  <= ps2d_p0;
         // glitch filter: cnt counts consecutive samples differing from filt
         fe <= 1'b0;
         if (ps2c_p1 == filt) begin
            cnt <= 5'd0;
         end else if (cnt == CNT_MAX) begin
            filt <= ps2c_p1;
            cnt  <= 5'd0;
            fe   <= filt;     // old level 1 means this is a 1->0 change
         end else begin
            cnt <= cnt + 5'd1;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_decod.sv
// ps2_rx_decod -- PS/2 keyboard receiver and scan code decoder (set 2).
//   Frames are received on filtered falling edges of ps2c, checked for stop
//   bit (and optionally parity), and valid make codes are decoded into
//   single-cycle command pulses.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   ps2c, ps2d PS/2 clock / data pins
//   ctrl       pulse on a Ctrl make code
//   enter      pulse on an Enter make code
//   dato       pulse on a hex digit make code
//   dato_hex   last decoded digit, held until the next dato
//   rx_err     pulse on framing / parity / watchdog error
// Configuration macro:
//   PS2_PARITY_CHECK_EN  when defined, bad parity raises rx_err and drops
//                        the byte; otherwise the parity bit is ignored.
module ps2_rx_decod
   import ps2_pkg::*;
#(
   parameter int FILTRO_LEN = 8,
   parameter int WATCHDOG   = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2c,
   input  logic       ps2d,
   output logic       ctrl,
   output logic       enter,
   output logic       dato,
   output logic [3:0] dato_hex,
   output logic       rx_err
);

   localparam int             WD_W    = $clog2(WATCHDOG + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);

   logic            fe;
   logic            dat;
   rx_state_t       state;
   logic [7:0]      sh;
   logic [2:0]      bit_cnt;
   logic [WD_W-1:0] wd;
   logic            brk, ext;
   logic            parity_ok;
   logic            frame_ok;
   logic [4:0]      hex_dec;

   ps2_filtro #(
      .FILTRO_LEN(FILTRO_LEN)
   ) u_filtro (
      .clk    (clk),
      .rst    (rst),
      .ps2c   (ps2c),
      .ps2d   (ps2d),
      .fe     (fe),
      .ps2d_s (dat)
   );

`ifdef PS2_PARITY_CHECK_EN
   logic par;
   // odd parity over 8 data bits plus parity bit
   assign parity_ok = ^{sh, par};
`else
   assign parity_ok = 1'b1;
`endif

   // dat is the stop bit while state==RX_STOP
   assign frame_ok = dat & parity_ok;
   assign hex_dec  = sc_to_hex(sh);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RX_IDLE;
         sh       <= 8'h00;
         bit_cnt  <= 3'd0;
         wd       <= '0;
         brk      <= 1'b0;
         ext      <= 1'b0;
         ctrl     <= 1'b0;
         enter    <= 1'b0;
         dato     <= 1'b0;
         dato_hex <= 4'h0;
         rx_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par      <= 1'b0;
`endif
      end else begin
         ctrl   <= 1'b0;
         enter  <= 1'b0;
         dato   <= 1'b0;
         rx_err <= 1'b0;

         // watchdog: idle or any edge restarts it
         if (state == RX_IDLE || fe) wd <= '0;
         else                        wd <= wd + 1'b1;

         case (state)
            RX_IDLE: begin
               if (fe && !dat) begin
                  state   <= RX_DATA;
                  bit_cnt <= 3'd0;
               end
            end
            RX_DATA: begin
               if (fe) begin
                  sh      <= {dat, sh[7:1]};   // LSB arrives first
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= RX_PAR;
               end
            end
            RX_PAR: begin
               if (fe) begin
`ifdef PS2_PARITY_CHECK_EN
                  par   <= dat;
`endif
                  state <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (fe) begin
                  state <= RX_IDLE;
                  if (!frame_ok) begin
                     rx_err <= 1'b1;
                     brk    <= 1'b0;
                     ext    <= 1'b0;
                  end else if (sh == SC_EXT) begin
                     ext <= 1'b1;
                  end else if (sh == SC_BRK) begin
                     brk <= 1'b1;
                  end else begin
                     // a released key's code is swallowed; prefixes end here
                     if (brk || ext) begin
                        brk <= 1'b0;
                        ext <= 1'b0;
                     end
                     if (!brk) begin
                        if (sh == SC_CTRL) begin
                           ctrl <= 1'b1;
                        end else if (sh == SC_ENTER) begin
                           enter <= 1'b1;
                        end else if (hex_dec[4]) begin
                           dato     <= 1'b1;
                           dato_hex <= hex_dec[3:0];
                        end
                     end
                  end
               end
            end
            default: state <= RX_IDLE;
         endcase

         // expiry overrides the state update: edges never coincide with it
         if (state != RX_IDLE && !fe && wd == WD_LAST) begin
            state  <= RX_IDLE;
            wd     <= '0;
            rx_err <= 1'b1;
            brk    <= 1'b0;
            ext    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx_decod.sv
module tb_ps2_rx_decod;

   localparam int FL = 4;      // filter length used for the bench build
   localparam int WD = 200;    // watchdog length used for the bench build
   localparam int H  = 16;     // half bit period in clk cycles

   localparam int K_NONE = 0, K_CTRL = 1, K_ENTER = 2, K_DATO = 3, K_ERR = 4;

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2c = 1'b1;
   logic       ps2d = 1'b1;
   logic       ctrl, enter, dato, rx_err;
   logic [3:0] dato_hex;

   ps2_rx_decod #(
      .FILTRO_LEN(FL),
      .WATCHDOG  (WD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2c     (ps2c),
      .ps2d     (ps2d),
      .ctrl     (ctrl),
      .enter    (enter),
      .dato     (dato),
      .dato_hex (dato_hex),
      .rx_err   (rx_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [7:0] dig_codes [0:15] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
   bit         m_brk = 1'b0;
   bit         m_ext = 1'b0;
   logic [3:0] m_hex = 4'h0;
   int         exp_cyc  = -1;
   int         exp_kind = K_NONE;
   logic [3:0] exp_hex  = 4'h0;

   int n_ctrl = 0, n_enter = 0, n_dato = 0, n_err = 0;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   // per-cycle comparison against the model
   logic e_c, e_e, e_d, e_r;
   always @(negedge clk) begin
      e_c = 1'b0; e_e = 1'b0; e_d = 1'b0; e_r = 1'b0;
      if (!rst && cyc == exp_cyc) begin
         case (exp_kind)
            K_CTRL:  e_c = 1'b1;
            K_ENTER: e_e = 1'b1;
            K_DATO:  begin e_d = 1'b1; m_hex = exp_hex; end
            K_ERR:   e_r = 1'b1;
            default: ;
         endcase
      end
      check("ctrl",     int'(ctrl),     int'(e_c));
      check("enter",    int'(enter),    int'(e_e));
      check("dato",     int'(dato),     int'(e_d));
      check("rx_err",   int'(rx_err),   int'(e_r));
      check("dato_hex", int'(dato_hex), int'(m_hex));
      if (ctrl)   n_ctrl++;
      if (enter)  n_enter++;
      if (dato)   n_dato++;
      if (rx_err) n_err++;
   end

   // outcome of one frame according to the decoding rules
   task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      bit valid;
      valid    = !bad_stop && !(bad_par && PAR_EN);
      exp_kind = K_NONE;
      if (!valid) begin
         exp_kind = K_ERR;
         m_brk = 1'b0; m_ext = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         if (!m_brk) begin
            if (b == 8'h14) exp_kind = K_CTRL;
            else if (b == 8'h5A) exp_kind = K_ENTER;
            else begin
               for (int i = 0; i < 16; i++)
                  if (dig_codes[i] == b) begin
                     exp_kind = K_DATO;
                     exp_hex  = 4'(i);
                  end
            end
         end
         m_brk = 1'b0; m_ext = 1'b0;
      end
   endtask

   // one bit: data set up, ps2c low for H cycles, then high; returns cycle of the drop
   task automatic send_bit(input logic v, output int drop_cyc);
      @(posedge clk); #1;
      ps2d = v;
      repeat (H) @(posedge clk);
      #1;
      ps2c = 1'b0;
      drop_cyc = cyc;
      repeat (H) @(posedge clk);
      #1;
      ps2c = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic [10:0] bits;
      int          dc;
      bits[0]   = 1'b0;
      bits[8:1] = b;
      bits[9]   = (~^b) ^ bad_par;
      bits[10]  = ~bad_stop;
      model_frame(b, bad_par, bad_stop);
      for (int i = 0; i < 11; i++) begin
         if (i == 10) begin
            // expectation armed before the drop so the stop edge can be timed
            @(posedge clk); #1;
            ps2d = bits[10];
            repeat (H) @(posedge clk);
            #1;
            ps2c = 1'b0;
            exp_cyc = cyc + FL + 3;
            repeat (H) @(posedge clk);
            #1;
            ps2c = 1'b1;
         end else begin
            send_bit(bits[i], dc);
         end
      end
      ps2d = 1'b1;
      repeat (2 * H) @(posedge clk);
   endtask

   int c0, c1, c2, c3, dc;
   logic [7:0] rb;
   int sel;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl",  int'(ctrl),     0);
      check("rst_enter", int'(enter),    0);
      check("rst_dato",  int'(dato),     0);
      check("rst_err",   int'(rx_err),   0);
      check("rst_hex",   int'(dato_hex), 0);
      rst = 1'b0;
      repeat (10) @(posedge clk);

      // Enter make code
      c0 = n_enter; c1 = n_dato; c2 = n_ctrl; c3 = n_err;
      send_frame(8'h5A, 1'b0, 1'b0);
      check("enter_cnt", n_enter - c0, 1);
      check("enter_other", (n_dato - c1) + (n_ctrl - c2) + (n_err - c3), 0);

      // digit 3 make, then its release
      c0 = n_dato;
      send_frame(8'h26, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h26, 1'b0, 1'b0);
      check("d3_cnt", n_dato - c0, 1);
      check("d3_hex", int'(dato_hex), 3);

      // right Ctrl make and release, then digit A
      c0 = n_ctrl; c1 = n_dato;
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h14, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h14, 1'b0, 1'b0);
      check("rctrl_cnt", n_ctrl - c0, 1);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("dA_cnt", n_dato - c1, 1);
      check("dA_hex", int'(dato_hex), 10);

      // digit 0 with bad parity
      c0 = n_dato; c1 = n_err;
      send_frame(8'h45, 1'b1, 1'b0);
      if (PAR_EN) begin
         check("badpar_err",  n_err - c1, 1);
         check("badpar_dato", n_dato - c0, 0);
         check("badpar_hex",  int'(dato_hex), 10);
      end else begin
         check("badpar_err",  n_err - c1, 0);
         check("badpar_dato", n_dato - c0, 1);
         check("badpar_hex",  int'(dato_hex), 0);
      end

      // watchdog: start bit plus 4 data bits of 0x16, then silence
      c1 = n_err;
      send_bit(1'b0, dc);
      for (int i = 0; i < 4; i++) send_bit(rb[0] ^ rb[0] ^ (((8'h16 >> i) & 8'h01) != 0), dc);
      exp_kind = K_ERR;
      exp_cyc  = dc + FL + 3 + WD;
      m_brk = 1'b0; m_ext = 1'b0;
      ps2d = 1'b1;
      repeat (WD + 40) @(posedge clk);
      check("wd_err", n_err - c1, 1);
      send_frame(8'h16, 1'b0, 1'b0);
      check("wd_d1_hex", int'(dato_hex), 1);

      // reset during the parity bit of a released-key frame
      send_frame(8'hF0, 1'b0, 1'b0);
      c1 = n_err;
      send_bit(1'b0, dc);
      for (int i = 0; i < 8; i++) send_bit(((8'h5A >> i) & 8'h01) != 0, dc);
      @(posedge clk); #1;
      ps2d = ~^8'h5A;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      m_brk = 1'b0; m_ext = 1'b0; m_hex = 4'h0; exp_cyc = -1;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_outs", int'({ctrl, enter, dato, rx_err, dato_hex}), 0);
      rst  = 1'b0;
      ps2d = 1'b1;
      repeat (WD + 40) @(posedge clk);
      check("mid_rst_noerr", n_err - c1, 0);
      c0 = n_dato;
      send_frame(8'h26, 1'b0, 1'b0);
      check("post_rst_d3", n_dato - c0, 1);

      // one-cycle glitch on ps2c with data low
      @(posedge clk); #1;
      ps2d = 1'b0;
      ps2c = 1'b0;
      @(posedge clk); #1;
      ps2c = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      ps2d = 1'b1;
      c0 = n_dato;
      send_frame(8'h16, 1'b0, 1'b0);
      check("glitch_d1_cnt", n_dato - c0, 1);
      check("glitch_d1_hex", int'(dato_hex), 1);

      // randomized frames
      for (int n = 0; n < 80; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3: rb = dig_codes[$urandom_range(0, 15)];
            4:          rb = 8'h14;
            5:          rb = 8'h5A;
            6:          rb = 8'hE0;
            7:          rb = 8'hF0;
            8:          rb = 8'($urandom_range(0, 255));
            default:    rb = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'hFA;
         endcase
         send_frame(rb, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end
      repeat (20) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
